drum_timing_track: RTL and testbench
====================================

Name: drum_timing_track

Overview:
- Upstream timing source for the T4/T7/T39 phase logic.
- Replaces the behavioural Z2/Z3 stimulus with synthesizable RTL.
- From the bit clock (Z1), generates the timing-track signals read off the drum: the Z2 word-sync pattern and the Z3 serial sector-address field. Also exposes bit/word counters for downstream decoding.
- One word is BPW bit-times; one revolution is WORDS words.

Parameters:
- BPW, 40, bit-times per word; must be >= ADDR_W+10.
- ADDR_W, 7, sector-address width serialised on Z3.
- WORDS, 128, words per revolution; must be <= 2**ADDR_W.

Ports:
- CLK  input  1  bit clock (Z1); all state updates on falling edge, matching master-slave FF output timing.
- CLR  input  1  asynchronous active-low reset.
- EN  input  1  drum up to speed; when low, counters and outputs hold.
- Z2  output  1  word-sync track.
- _Z2  output  1  complement of Z2.
- Z3  output  1  serial address track.
- _Z3  output  1  complement of Z3.
- BIT  output  6  current bit-time index within word, 0..BPW-1.
- WORD  output  ADDR_W  current word index, 0..WORDS-1.
- IDX  output  1  revolution index: high during bit 0 of word 0.
- WEND  output  1  high during bit BPW-1 of every word.

Behaviour:
- Reset (CLR low, asynchronous, dominates EN and CLK):
  - BIT=0, WORD=0, Z2=0, Z3=0, IDX=1, WEND=0.
  - _Z2=1, _Z3=1.
  - Reset mid-word discards the partial word.
  - First edge after CLR release advances to BIT=1.
- Counting, on each CLK falling edge with EN=1:
  - BIT increments.
  - At BIT=BPW-1, BIT wraps to 0 and WORD increments.
  - At WORD=WORDS-1 with BIT=BPW-1, WORD wraps to 0.
- With EN=0, all registers hold. Z2/Z3 keep their last values; no glitch.
- Outputs are pure registered decodes of the next BIT/WORD, so they change only at the CLK falling edge. Zero combinational path from inputs to outputs except CLR.
- Z2 pattern by bit index b (defaults in parentheses):
  - Low for b=0..BPW-10 (0..30).
  - High for b=BPW-9..BPW-7 (31..33).
  - Low for b=BPW-6..BPW-3 (34..37).
  - High for b=BPW-2..BPW-1 (38..39).
- Z3 field:
  - Z3=0 for b<BPW-ADDR_W-1 (b<32).
  - At b=BPW-ADDR_W-1+k, k=0..ADDR_W-1 (32..38), Z3 = A[k], LSB first.
  - At b=BPW-1 (39), Z3=0.
  - A = (WORD+1) mod WORDS: the field announces the next sector (sector-ahead addressing).
  - In word WORDS-1, A=0.
- IDX = (WORD==0 && BIT==0). WEND = (BIT==BPW-1).
- Complement outputs are always exact inverses, including during reset.
- Elaboration fails if BPW < ADDR_W+10 or WORDS > 2**ADDR_W.

Test Plan:
- CLR low 5 cycles, release, EN=1:
  - During reset: BIT=0, WORD=0, Z2=0, Z3=0, _Z2=1, _Z3=1, IDX=1.
  - After 1st falling edge: BIT=1, IDX=0.
- Run word 0 (WORD=0):
  - Z2 bit sequence 31x0, 3x1, 4x0, 2x1.
  - Z3 low bits 0..31; bits 32..38 = 1,0,0,0,0,0,0 (address 1); bit 39 = 0.
  - WEND high only at bit 39.
- Run to WORD=5:
  - Z3 bits 32..38 = 0,1,1,0,0,0,0 (address 6).
- Run to WORD=127:
  - Z3 field all 0 (address 0).
  - After bit 39: WORD=0, BIT=0, IDX=1.
  - Full revolution = 5120 falling edges.
- EN dropped at WORD=3, BIT=33 (Z2=1) for 10 cycles:
  - BIT/WORD/Z2/Z3 frozen.
  - On re-enable, next edge gives BIT=34, Z2=0.
- CLR pulsed low between clock edges at WORD=9, BIT=35:
  - Outputs go to reset values immediately, without a clock edge.
  - Counting restarts from WORD=0, BIT=0 after release.

Source files
------------

// File: rtl/drum_timing_track.sv
// Drum timing-track generator: derives the Z2 word-sync and Z3 serial sector-address
// tracks, plus bit/word position counters, from the Z1 bit clock.
module drum_timing_track #(
  parameter int unsigned BPW    = 40,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WORDS  = 128
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              EN,
  output logic              Z2,
  output logic              _Z2,
  output logic              Z3,
  output logic              _Z3,
  output logic [5:0]        BIT,
  output logic [ADDR_W-1:0] WORD,
  output logic              IDX,
  output logic              WEND
);

  if (BPW < ADDR_W + 10) begin : g_bad_bpw
    $error("drum_timing_track: BPW must be >= ADDR_W+10");
  end
  if (WORDS > (1 << ADDR_W)) begin : g_bad_words
    $error("drum_timing_track: WORDS must be <= 2**ADDR_W");
  end
  if (BPW > 64) begin : g_bad_bit_width
    $error("drum_timing_track: BPW must fit the 6-bit BIT output");
  end

  localparam logic [5:0]        LAST_BIT  = 6'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [5:0]        Z2_A_LO   = 6'(BPW - 9);
  localparam logic [5:0]        Z2_A_HI   = 6'(BPW - 7);
  localparam logic [5:0]        Z2_B_LO   = 6'(BPW - 2);
  localparam int unsigned       Z3_START  = BPW - ADDR_W - 1;

  logic [5:0]        bit_q,  bit_nxt;
  logic [ADDR_W-1:0] word_q, word_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              z2_q, z2_nxt;
  logic              z3_q, z3_nxt;
  logic              idx_q, idx_nxt;
  logic              wend_q, wend_nxt;

  // Outputs are decoded from the next position so they register in step with the counters.
  always_comb begin
    bit_nxt  = bit_q + 6'd1;
    word_nxt = word_q;
    if (bit_q == LAST_BIT) begin
      bit_nxt  = '0;
      word_nxt = (word_q == LAST_WORD) ? '0 : word_q + 1'b1;
    end

    // Sector-ahead addressing: the field announces the word that follows.
    addr_nxt = (word_nxt == LAST_WORD) ? '0 : word_nxt + 1'b1;

    z2_nxt = ((bit_nxt >= Z2_A_LO) && (bit_nxt <= Z2_A_HI)) || (bit_nxt >= Z2_B_LO);

    z3_nxt = 1'b0;
    for (int unsigned k = 0; k < ADDR_W; k++) begin
      if (bit_nxt == 6'(Z3_START + k)) begin
        z3_nxt = addr_nxt[k];
      end
    end

    idx_nxt  = (word_nxt == '0) && (bit_nxt == '0);
    wend_nxt = (bit_nxt == LAST_BIT);
  end

  // Falling-edge update mirrors master-slave flip-flop output timing on the drum.
  always_ff @(negedge CLK or negedge CLR) begin
    if (!CLR) begin
      bit_q  <= '0;
      word_q <= '0;
      z2_q   <= 1'b0;
      z3_q   <= 1'b0;
      idx_q  <= 1'b1;
      wend_q <= 1'b0;
    end else if (EN) begin
      bit_q  <= bit_nxt;
      word_q <= word_nxt;
      z2_q   <= z2_nxt;
      z3_q   <= z3_nxt;
      idx_q  <= idx_nxt;
      wend_q <= wend_nxt;
    end
  end

  assign Z2   = z2_q;
  assign _Z2  = ~z2_q;
  assign Z3   = z3_q;
  assign _Z3  = ~z3_q;
  assign BIT  = bit_q;
  assign WORD = word_q;
  assign IDX  = idx_q;
  assign WEND = wend_q;

endmodule

// File: tb/tb_drum_timing_track.sv
// Directed bench for drum_timing_track with default parameters (BPW=40, ADDR_W=7, WORDS=128).
module tb_drum_timing_track;

  logic       clk;
  logic       clr;
  logic       en;
  logic       z2, nz2, z3, nz3, idx, wend;
  logic [5:0] bitc;
  logic [6:0] word;

  int checks;
  int failures;

  drum_timing_track #(.BPW(40), .ADDR_W(7), .WORDS(128)) dut (
    .CLK(clk), .CLR(clr), .EN(en),
    .Z2(z2), ._Z2(nz2), .Z3(z3), ._Z3(nz3),
    .BIT(bitc), .WORD(word), .IDX(idx), .WEND(wend)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Each call lets n falling edges pass; sampling happens on the rising edge.
  task automatic advance(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset;
    clr = 1'b1;
    en  = 1'b0;
    #2 clr = 1'b0;
    advance(5);
    checks++; if (bitc !== 6'd0) begin failures++; $display("FAIL reset_bit got=%0d exp=0", bitc); end
    checks++; if (word !== 7'd0) begin failures++; $display("FAIL reset_word got=%0d exp=0", word); end
    checks++; if (z2 !== 1'b0 || nz2 !== 1'b1) begin failures++; $display("FAIL reset_z2 got=%b/%b exp=0/1", z2, nz2); end
    checks++; if (z3 !== 1'b0 || nz3 !== 1'b1) begin failures++; $display("FAIL reset_z3 got=%b/%b exp=0/1", z3, nz3); end
    checks++; if (idx !== 1'b1 || wend !== 1'b0) begin failures++; $display("FAIL reset_idx_wend got=%b/%b exp=1/0", idx, wend); end
    clr = 1'b1;
    en  = 1'b1;
    advance(1);
    checks++; if (bitc !== 6'd1 || idx !== 1'b0 || word !== 7'd0) begin
      failures++; $display("FAIL first_edge got bit=%0d idx=%b word=%0d exp bit=1 idx=0 word=0", bitc, idx, word);
    end
  endtask

  // Word 0: address field carries 1 -> bits 32..38 = 1,0,0,0,0,0,0.
  task automatic test_word0;
    logic ez2, ez3, ewend;
    for (int b = 1; b < 40; b++) begin
      if (b > 1) advance(1);
      ez2   = (b >= 31 && b <= 33) || (b >= 38);
      ez3   = (b == 32);
      ewend = (b == 39);
      checks++; if (bitc !== 6'(b) || word !== 7'd0) begin failures++; $display("FAIL w0_pos got=%0d/%0d exp=0/%0d", word, bitc, b); end
      checks++; if (z2 !== ez2 || nz2 !== ~ez2) begin failures++; $display("FAIL w0_z2 bit=%0d got=%b/%b exp=%b", b, z2, nz2, ez2); end
      checks++; if (z3 !== ez3 || nz3 !== ~ez3) begin failures++; $display("FAIL w0_z3 bit=%0d got=%b/%b exp=%b", b, z3, nz3, ez3); end
      checks++; if (wend !== ewend) begin failures++; $display("FAIL w0_wend bit=%0d got=%b exp=%b", b, wend, ewend); end
    end
  endtask

  // Word 5: address 6 -> bits 32..38 = 0,1,1,0,0,0,0.
  task automatic test_addr_word5;
    logic [7:0] field;
    field = 8'b0000_0110;
    advance(193);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) advance(1);
      checks++; if (word !== 7'd5 || bitc !== 6'(32 + k)) begin failures++; $display("FAIL w5_pos got=%0d/%0d exp=5/%0d", word, bitc, 32 + k); end
      checks++; if (z3 !== field[k] || nz3 !== ~field[k]) begin failures++; $display("FAIL w5_z3 bit=%0d got=%b exp=%b", 32 + k, z3, field[k]); end
    end
  endtask

  task automatic test_wrap;
    advance(4873);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) advance(1);
      checks++; if (word !== 7'd127 || bitc !== 6'(32 + k)) begin failures++; $display("FAIL w127_pos got=%0d/%0d exp=127/%0d", word, bitc, 32 + k); end
      checks++; if (z3 !== 1'b0) begin failures++; $display("FAIL w127_z3 bit=%0d got=%b exp=0", 32 + k, z3); end
    end
    advance(1);
    checks++; if (word !== 7'd0 || bitc !== 6'd0 || idx !== 1'b1) begin
      failures++; $display("FAIL wrap got word=%0d bit=%0d idx=%b exp 0/0/1", word, bitc, idx);
    end
    advance(1);
    checks++; if (idx !== 1'b0) begin failures++; $display("FAIL idx_drop got=%b exp=0", idx); end
    advance(5119);
    checks++; if (word !== 7'd0 || bitc !== 6'd0 || idx !== 1'b1) begin
      failures++; $display("FAIL revolution got word=%0d bit=%0d idx=%b exp 0/0/1", word, bitc, idx);
    end
  endtask

  task automatic test_enable_hold;
    advance(153);
    checks++; if (word !== 7'd3 || bitc !== 6'd33 || z2 !== 1'b1) begin
      failures++; $display("FAIL hold_setup got word=%0d bit=%0d z2=%b exp 3/33/1", word, bitc, z2);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      advance(1);
      checks++; if (word !== 7'd3 || bitc !== 6'd33 || z2 !== 1'b1 || z3 !== 1'b0) begin
        failures++; $display("FAIL hold cycle=%0d got word=%0d bit=%0d z2=%b z3=%b exp 3/33/1/0", i, word, bitc, z2, z3);
      end
    end
    en = 1'b1;
    advance(1);
    checks++; if (bitc !== 6'd34 || z2 !== 1'b0 || nz2 !== 1'b1) begin
      failures++; $display("FAIL resume got bit=%0d z2=%b exp 34/0", bitc, z2);
    end
  endtask

  // Word 9 announces address 10 (0001010): bit 35 carries A[3] = 1.
  task automatic test_async_clear;
    advance(241);
    checks++; if (word !== 7'd9 || bitc !== 6'd35 || z3 !== 1'b1) begin
      failures++; $display("FAIL clr_setup got word=%0d bit=%0d z3=%b exp 9/35/1", word, bitc, z3);
    end
    #2 clr = 1'b0;
    #1;
    checks++; if (word !== 7'd0 || bitc !== 6'd0 || idx !== 1'b1) begin
      failures++; $display("FAIL clr_async got word=%0d bit=%0d idx=%b exp 0/0/1", word, bitc, idx);
    end
    checks++; if (z3 !== 1'b0 || nz3 !== 1'b1 || z2 !== 1'b0 || nz2 !== 1'b1) begin
      failures++; $display("FAIL clr_async_tracks got z2=%b z3=%b exp 0/0", z2, z3);
    end
    advance(1);
    checks++; if (bitc !== 6'd0 || word !== 7'd0) begin failures++; $display("FAIL clr_held got bit=%0d word=%0d exp 0/0", bitc, word); end
    #2 clr = 1'b1;
    advance(1);
    checks++; if (bitc !== 6'd1 || word !== 7'd0 || idx !== 1'b0) begin
      failures++; $display("FAIL clr_restart got bit=%0d word=%0d idx=%b exp 1/0/0", bitc, word, idx);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_word0;
    test_addr_word5;
    test_wrap;
    test_enable_hold;
    test_async_clear;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
